// File: rtl/lis_stream_ctrl_if.sv
// Handshake bundle for lis_stream_ctrl: job control, byte streams, sorter port and status.
// The slave modport is the controller's view; master is the surrounding environment.
interface lis_stream_ctrl_if;
   logic        start;
   logic        bist_en;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_last;
   logic        in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_ready;
   logic        srt_clear;
   logic        srt_in_valid;
   logic [31:0] srt_in_data;
   logic        srt_in_ready;
   logic        srt_out_valid;
   logic [31:0] srt_out_data;
   logic        srt_out_ready;
   logic        busy;
   logic        done;
   logic [8:0]  word_cnt;

   modport slave (
      input  start, bist_en, in_valid, in_data, in_last, out_ready,
             srt_in_ready, srt_out_valid, srt_out_data,
      output in_ready, out_valid, out_data, srt_clear, srt_in_valid, srt_in_data,
             srt_out_ready, busy, done, word_cnt
   );

   modport master (
      output start, bist_en, in_valid, in_data, in_last, out_ready,
             srt_in_ready, srt_out_valid, srt_out_data,
      input  in_ready, out_valid, out_data, srt_clear, srt_in_valid, srt_in_data,
             srt_out_ready, busy, done, word_cnt
   );
endinterface

// File: rtl/lis_stream_ctrl.sv
// Stream controller for an external word sorter: packs bytes (or BIST LFSR words) into
// 32-bit words, loads the sorter, then drains sorted words back out as MSB-first bytes.
module lis_stream_ctrl #(
   parameter int unsigned LIS_SIZE  = 8,
   parameter logic [31:0] BIST_SEED = 32'hACE12345
) (
   input logic              clock,
   input logic              reset,
   lis_stream_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

   localparam logic [8:0]  SIZE = 9'(LIS_SIZE);
   localparam logic [31:0] POLY = 32'h80200003;

   state_t      state;
   logic        bist_mode;
   logic        last_seen;
   logic        stage_last;
   logic [31:0] lfsr;
   logic [31:0] asm_word;
   logic [31:0] stage;
   logic [31:0] shreg;
   logic [1:0]  byte_idx;
   logic [2:0]  sh_cnt;
   logic [8:0]  word_cnt;
   logic [8:0]  formed;
   logic [8:0]  popped;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        srt_in_valid;
   logic        srt_clear;
   logic        busy;
   logic        done;

   logic        in_ready_c;
   logic        srt_out_ready_c;
   logic        push;
   logic        pop;
   logic        take_byte;
   logic        out_free;
   logic [31:0] asm_next;

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return {1'b0, s[31:1]} ^ (s[0] ? POLY : 32'h0);
   endfunction

   // Ready signals look at the partner's ready so a word can leave the staging
   // register in the same cycle the next one completes: one byte per cycle.
   always_comb begin
      in_ready_c      = (state == LOAD) && !bist_mode && !last_seen && (formed < SIZE) &&
                        (!srt_in_valid || bus.srt_in_ready);
      push            = srt_in_valid && bus.srt_in_ready;
      take_byte       = bus.in_valid && in_ready_c;
      asm_next        = asm_word | ({24'd0, bus.in_data} << (5'd24 - {byte_idx, 3'b000}));
      srt_out_ready_c = (state == DRAIN) && (sh_cnt == 3'd0) && (popped < word_cnt);
      pop             = srt_out_ready_c && bus.srt_out_valid;
      out_free        = !out_valid || bus.out_ready;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         bist_mode    <= 1'b0;
         last_seen    <= 1'b0;
         stage_last   <= 1'b0;
         lfsr         <= BIST_SEED;
         asm_word     <= '0;
         stage        <= '0;
         shreg        <= '0;
         byte_idx     <= '0;
         sh_cnt       <= '0;
         word_cnt     <= '0;
         formed       <= '0;
         popped       <= '0;
         out_valid    <= 1'b0;
         out_data     <= '0;
         srt_in_valid <= 1'b0;
         srt_clear    <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         srt_clear <= 1'b0;
         done      <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state        <= LOAD;
                  busy         <= 1'b1;
                  srt_clear    <= 1'b1;
                  bist_mode    <= bus.bist_en;
                  word_cnt     <= '0;
                  formed       <= '0;
                  popped       <= '0;
                  last_seen    <= 1'b0;
                  stage_last   <= 1'b0;
                  byte_idx     <= '0;
                  asm_word     <= '0;
                  lfsr         <= BIST_SEED;
                  srt_in_valid <= 1'b0;
                  sh_cnt       <= '0;
               end
            end

            LOAD: begin
               if (push) begin
                  word_cnt     <= word_cnt + 9'd1;
                  srt_in_valid <= 1'b0;
                  if (stage_last || (word_cnt == SIZE - 9'd1))
                     state <= DRAIN;
               end
               if (bist_mode) begin
                  if ((!srt_in_valid || push) && (formed < SIZE)) begin
                     stage        <= lfsr;
                     stage_last   <= 1'b0;
                     srt_in_valid <= 1'b1;
                     lfsr         <= lfsr_step(lfsr);
                     formed       <= formed + 9'd1;
                  end
               end else if (take_byte) begin
                  if ((byte_idx == 2'd3) || bus.in_last) begin
                     stage        <= asm_next;
                     stage_last   <= bus.in_last;
                     srt_in_valid <= 1'b1;
                     formed       <= formed + 9'd1;
                     asm_word     <= '0;
                     byte_idx     <= '0;
                     last_seen    <= bus.in_last;
                  end else begin
                     asm_word <= asm_next;
                     byte_idx <= byte_idx + 2'd1;
                  end
               end
            end

            DRAIN: begin
               if (pop)
                  popped <= popped + 9'd1;
               // A freshly popped word bypasses the shift register when the output
               // stage is free, so its first byte appears without a bubble.
               if (out_free) begin
                  if (sh_cnt != 3'd0) begin
                     out_data  <= shreg[31:24];
                     out_valid <= 1'b1;
                     shreg     <= {shreg[23:0], 8'h00};
                     sh_cnt    <= sh_cnt - 3'd1;
                  end else if (pop) begin
                     out_data  <= bus.srt_out_data[31:24];
                     out_valid <= 1'b1;
                     shreg     <= {bus.srt_out_data[23:0], 8'h00};
                     sh_cnt    <= 3'd3;
                  end else begin
                     out_valid <= 1'b0;
                     if (popped == word_cnt) begin
                        state <= DONE;
                        done  <= 1'b1;
                     end
                  end
               end else if (pop) begin
                  shreg  <= bus.srt_out_data;
                  sh_cnt <= 3'd4;
               end
            end

            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready      = in_ready_c;
   assign bus.out_valid     = out_valid;
   assign bus.out_data      = out_data;
   assign bus.srt_clear     = srt_clear;
   assign bus.srt_in_valid  = srt_in_valid;
   assign bus.srt_in_data   = stage;
   assign bus.srt_out_ready = srt_out_ready_c;
   assign bus.busy          = busy;
   assign bus.done          = done;
   assign bus.word_cnt      = word_cnt;

endmodule

// File: doc/lis_stream_ctrl.md
LIS_STREAM_CTRL -- requirements
Module: lis_stream_ctrl

Interface
REQ-001 SHALL have parameter LIS_SIZE, default 8: sorter capacity in 32-bit words (range 2..256).
REQ-002 SHALL have parameter BIST_SEED, default 32'hACE12345: first BIST word; SHALL be nonzero.
REQ-003 SHALL have a single clock `clock`; reset `reset` is asynchronous and active-high.
REQ-004 clock  in  1  system clock; all state updates on its rising edge.
REQ-005 reset  in  1  async active-high reset.
REQ-006 start  in  1  one-cycle pulse that begins a sort job; honoured only in IDLE.
REQ-007 bist_en  in  1  job source select, sampled with start: 1 = internal LFSR, 0 = byte input stream.
REQ-008 in_valid, in_data[7:0], in_last  in  1/8/1  byte input stream; in_last marks the final byte of a job.
REQ-009 in_ready  out  1  byte accepted when in_valid && in_ready on a clock edge.
REQ-010 out_valid, out_data[7:0]  out  1/8  sorted byte output stream.
REQ-011 out_ready  in  1  byte consumed when out_valid && out_ready.
REQ-012 srt_clear  out  1  one-cycle pulse that empties the sorter.
REQ-013 srt_in_valid, srt_in_data[31:0]  out  1/32  words pushed to sorter; srt_in_ready  in  1.
REQ-014 srt_out_valid, srt_out_data[31:0]  in  1/32  sorted words from sorter; srt_out_ready  out  1.
REQ-015 busy  out  1  high in any state other than IDLE; done  out  1  one-cycle pulse at job end.
REQ-016 word_cnt[8:0]  out  9  number of words loaded in the current or last job.

Function
REQ-017 States: IDLE, LOAD, DRAIN, DONE; start in IDLE -> LOAD with srt_clear=1 for that cycle and word_cnt cleared.
REQ-018 LOAD (ext): bytes packed MSB-first; 1st byte -> [31:24], 4th byte -> [7:0].
REQ-019 in_ready SHALL be 1 only in LOAD, ext mode, with no assembled word pending for the sorter.
REQ-020 A complete word SHALL drive srt_in_valid=1 with stable srt_in_data until srt_in_ready; word_cnt increments on that handshake.
REQ-021 in_last accepted on byte k (1..4) of a word: remaining bytes zero-filled; word pushed; no further bytes accepted.
REQ-022 LOAD -> DRAIN after the push handshake of the word with in_last, or when word_cnt reaches LIS_SIZE, whichever first.
REQ-023 LOAD (BIST): push LIS_SIZE words; word 0 = BIST_SEED; next word = Galois LFSR step, poly 0x80200003 (x^32+x^22+x^2+x+1), advanced on each push handshake; in_ready=0 throughout.
REQ-024 DRAIN: pop word_cnt words; srt_out_ready=1 only when the output shift register is empty; emit each word as 4 bytes MSB-first.
REQ-025 out_valid/out_data SHALL stay stable while out_ready=0; no byte dropped or duplicated.
REQ-026 After the last byte of the last word is consumed -> DONE: done=1 for one cycle, then IDLE.
REQ-027 start while busy=1 SHALL be ignored; bist_en changes mid-job SHALL have no effect.
REQ-028 srt_out_valid while not in DRAIN, and in_valid outside LOAD, SHALL be ignored.
REQ-029 Throughput: one byte per cycle sustained in both directions when the partner is always ready and the sorter accepts/returns in one cycle.

Reset
REQ-030 On reset assertion, immediately: state=IDLE; in_ready, out_valid, srt_in_valid, srt_out_ready, srt_clear, busy, done = 0; out_data=0; word_cnt=0; LFSR=BIST_SEED; partial byte assembly discarded.
REQ-031 Reset mid-job SHALL abandon the job; next job SHALL begin with srt_clear.

Verification
REQ-032 Ext load, LIS_SIZE=8, 32 bytes 01..20, in_last on byte 32 -> first push 0x01020304, word_cnt=8, 32 output bytes equal to the ideal sorted sequence, done once.
REQ-033 Ext, 6 bytes 01..06, in_last on 6th -> pushes 0x01020304, 0x05060000; word_cnt=2; exactly 8 bytes out; DONE.
REQ-034 BIST, LIS_SIZE=8 -> pushes 0xACE12345 then its LFSR successor ...; in_ready stays 0; 32 bytes out.
REQ-035 out_ready toggled 1/0 every cycle during DRAIN -> byte stream identical to REQ-032 and out_data stable while stalled.
REQ-036 Reset asserted after 3 output bytes in DRAIN -> all outputs at REQ-030 values that cycle; new start yields srt_clear and a correct full job.
REQ-037 start pulsed during LOAD and DRAIN -> no state change, no extra srt_clear, single done at job end.
